// File: rtl/rvfi_retire_fifo.sv
// RVFI retirement capture FIFO: compacts valid retire lanes into one queue, drains one record per
// cycle over valid/ready, and tracks order continuity, overflow drops and halt freeze.
module rvfi_retire_fifo #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ILEN  = 32,
  localparam int unsigned REC  = 64 + 4*ILEN + 7,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned LW   = PW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [ILEN*NRET-1:0] rvfi_insn,
  input  logic [NRET-1:0]      rvfi_trap,
  input  logic [NRET-1:0]      rvfi_halt,
  input  logic [ILEN*NRET-1:0] rvfi_pc_rdata,
  input  logic [ILEN*NRET-1:0] rvfi_pc_wdata,
  input  logic [5*NRET-1:0]    rvfi_rd_addr,
  input  logic [ILEN*NRET-1:0] rvfi_rd_wdata,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [REC-1:0]       out_rec_o,
  output logic [LW-1:0]        level_o,
  output logic                 overflow_o,
  output logic [15:0]          drop_cnt_o,
  output logic                 order_err_o,
  output logic [63:0]          err_order_o,
  output logic                 halted_o
);

  // state  | meaning
  // RUN    | capturing retire batches
  // FROZEN | halt record captured; new retires ignored, FIFO still drains
  typedef enum logic {RUN, FROZEN} state_e;

  state_e            state_q, state_d;
  logic [REC-1:0]    mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d, free, k;
  logic [NRET-1:0]   take;
  logic [PW-1:0]     slot [NRET];
  logic [REC-1:0]    lane_rec [NRET];
  logic              cut, accept, drop, pop;
  logic [63:0]       exp_q, exp_d, err_order_q, err_order_d;
  logic              order_err_q, order_err_d, overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [16:0]       drop_sum;

  // Lane selection: valid lanes in order, stopping after the first halt lane.
  always_comb begin
    k    = '0;
    take = '0;
    cut  = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      slot[i]     = '0;
      lane_rec[i] = {rvfi_order[i*64 +: 64], rvfi_insn[i*ILEN +: ILEN], rvfi_trap[i], rvfi_halt[i],
                     rvfi_pc_rdata[i*ILEN +: ILEN], rvfi_pc_wdata[i*ILEN +: ILEN],
                     rvfi_rd_addr[i*5 +: 5], rvfi_rd_wdata[i*ILEN +: ILEN]};
      if (rvfi_valid[i] && !cut && state_q == RUN) begin
        take[i] = 1'b1;
        slot[i] = k[PW-1:0];
        k       = k + LW'(1);
        cut     = rvfi_halt[i];
      end
    end
  end

  assign free   = LW'(DEPTH) - level_q;
  assign accept = (k != '0) && (free >= k);
  assign drop   = (k != '0) && !accept;
  assign pop    = out_valid_o && out_ready_i;

  always_comb begin
    exp_d       = exp_q;
    order_err_d = order_err_q;
    err_order_d = err_order_q;
    for (int i = 0; i < NRET; i++) begin
      if (take[i]) begin
        if (accept && rvfi_order[i*64 +: 64] != exp_d && !order_err_d) begin
          order_err_d = 1'b1;
          err_order_d = rvfi_order[i*64 +: 64];
        end
        // Dropped records still move the expectation so the next batch is judged fairly.
        exp_d = rvfi_order[i*64 +: 64] + 64'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q + (accept ? k : '0) - LW'(pop);
    overflow_d = overflow_q | drop;
    drop_sum   = {1'b0, drop_cnt_q} + 17'(k);
    drop_cnt_d = drop_cnt_q;
    if (accept) wr_ptr_d = wr_ptr_q + k[PW-1:0];
    if (pop)    rd_ptr_d = rd_ptr_q + PW'(1);
    if (drop)   drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    if (state_q == RUN && accept && cut) state_d = FROZEN;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      for (int i = 0; i < NRET; i++) begin
        if (take[i]) mem[wr_ptr_q + slot[i]] <= lane_rec[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      exp_q       <= '0;
      order_err_q <= 1'b0;
      err_order_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      exp_q       <= exp_d;
      order_err_q <= order_err_d;
      err_order_q <= err_order_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign out_valid_o = level_q != '0;
  assign out_rec_o   = out_valid_o ? mem[rd_ptr_q] : '0;
  assign level_o     = level_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;
  assign order_err_o = order_err_q;
  assign err_order_o = err_order_q;
  assign halted_o    = state_q == FROZEN;

endmodule

// File: tb/tb_rvfi_retire_fifo.sv
// Scoreboard bench for rvfi_retire_fifo: a queue-based reference model predicts accepted records
// and flags; a negedge monitor compares every drained head record against the queue.
module tb_rvfi_retire_fifo;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;
  localparam int ILEN  = 32;
  localparam int REC   = 64 + 4*ILEN + 7;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [REC-1:0] rec_t;

  logic                 clk, rst_n;
  logic [NRET-1:0]      rvfi_valid, rvfi_trap, rvfi_halt;
  logic [64*NRET-1:0]   rvfi_order;
  logic [ILEN*NRET-1:0] rvfi_insn, rvfi_pc_rdata, rvfi_pc_wdata, rvfi_rd_wdata;
  logic [5*NRET-1:0]    rvfi_rd_addr;
  logic                 out_valid, out_ready, overflow, order_err, halted;
  logic [REC-1:0]       out_rec;
  logic [LW-1:0]        level;
  logic [15:0]          drop_cnt;
  logic [63:0]          err_order;

  int n_tests = 0;
  int n_fail  = 0;

  rec_t        sb_q[$];
  logic [63:0] m_exp, m_err_order;
  logic        m_err, m_ovf, m_halted;
  int          m_drop;

  rvfi_retire_fifo #(.NRET(NRET), .DEPTH(DEPTH), .ILEN(ILEN)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata), .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_rec_o(out_rec), .level_o(level),
    .overflow_o(overflow), .drop_cnt_o(drop_cnt), .order_err_o(order_err),
    .err_order_o(err_order), .halted_o(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mon_level", 64'(level), 64'(sb_q.size()));
      chk("mon_valid", 64'(out_valid), 64'(sb_q.size() != 0));
      if (out_valid && out_ready && sb_q.size() != 0) begin
        rec_t e;
        e = sb_q.pop_front();
        n_tests++;
        if (out_rec !== e) begin
          n_fail++;
          $display("FAIL mon_rec: got 0x%0h expected 0x%0h at %0t", out_rec, e, $time);
        end
      end
    end
  end

  task automatic model_reset();
    sb_q.delete();
    m_exp = '0; m_err_order = '0; m_err = 1'b0; m_ovf = 1'b0; m_halted = 1'b0; m_drop = 0;
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_ovf"},   64'(overflow),  64'(m_ovf));
    chk({tag, "_drop"},  64'(drop_cnt),  64'(m_drop));
    chk({tag, "_oerr"},  64'(order_err), 64'(m_err));
    chk({tag, "_eord"},  err_order,      m_err_order);
    chk({tag, "_halt"},  64'(halted),    64'(m_halted));
  endtask

  // Called at posedge+1: drive one cycle of retires, predict, advance to next posedge+1.
  task automatic step(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1,
                      input logic [1:0] h, input logic rdy);
    logic [63:0] oo [2];
    rec_t        lr [2];
    rec_t        batch[$];
    logic [63:0] bo[$];
    logic        bh[$];
    rec_t        pend[$];
    int          k;
    oo[0] = o0; oo[1] = o1;
    out_ready = rdy; rvfi_valid = v; rvfi_halt = h;
    for (int i = 0; i < NRET; i++) begin
      rvfi_order[i*64 +: 64]      = oo[i];
      rvfi_insn[i*ILEN +: ILEN]   = $urandom;
      rvfi_trap[i]                = 1'($urandom);
      rvfi_pc_rdata[i*ILEN +: ILEN] = $urandom;
      rvfi_pc_wdata[i*ILEN +: ILEN] = $urandom;
      rvfi_rd_addr[i*5 +: 5]      = 5'($urandom);
      rvfi_rd_wdata[i*ILEN +: ILEN] = $urandom;
      lr[i] = {oo[i], rvfi_insn[i*ILEN +: ILEN], rvfi_trap[i], h[i], rvfi_pc_rdata[i*ILEN +: ILEN],
               rvfi_pc_wdata[i*ILEN +: ILEN], rvfi_rd_addr[i*5 +: 5], rvfi_rd_wdata[i*ILEN +: ILEN]};
    end
    if (!m_halted) begin
      for (int i = 0; i < NRET; i++) begin
        if (v[i]) begin
          batch.push_back(lr[i]); bo.push_back(oo[i]); bh.push_back(h[i]);
          if (h[i]) break;
        end
      end
    end
    k = batch.size();
    if (k > 0) begin
      if (DEPTH - sb_q.size() >= k) begin
        for (int j = 0; j < k; j++) begin
          if (bo[j] != m_exp && !m_err) begin m_err = 1'b1; m_err_order = bo[j]; end
          m_exp = bo[j] + 64'd1;
          pend.push_back(batch[j]);
          if (bh[j]) m_halted = 1'b1;
        end
      end else begin
        m_ovf  = 1'b1;
        m_drop = (m_drop + k > 65535) ? 65535 : m_drop + k;
        m_exp  = bo[k-1] + 64'd1;
      end
    end
    @(posedge clk);
    foreach (pend[j]) sb_q.push_back(pend[j]);
    #1;
    check_flags("step");
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, $urandom, $urandom, 2'b00, rdy);
  endtask

  task automatic drain();
    for (int c = 0; c < DEPTH + 4 && sb_q.size() != 0; c++) idle(1'b1);
    chk("drain_level", 64'(level), 64'd0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_rec",   64'(out_rec != '0), 64'd0);
    model_reset();
    check_flags("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1; rvfi_valid = '0;
  endtask

  task automatic rand_run(input int cycles, input int rdy_pct);
    logic [63:0] cur;
    logic [63:0] oo [2];
    logic [1:0]  v, h;
    cur = 0;
    for (int c = 0; c < cycles; c++) begin
      v = 2'($urandom);
      h = 2'b00;
      for (int i = 0; i < NRET; i++) begin
        if ($urandom_range(0, 19) == 0) cur = cur + 64'($urandom_range(1, 3));
        oo[i] = v[i] ? cur : 64'({$urandom, $urandom});
        if (v[i]) cur = cur + 1;
        if (v[i] && $urandom_range(0, 149) == 0) h[i] = 1'b1;
      end
      step(v, oo[0], oo[1], h, 1'($urandom_range(0, 99) < rdy_pct));
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b0; rvfi_valid = '0; rvfi_halt = '0; rvfi_trap = '0;
    rvfi_order = '0; rvfi_insn = '0; rvfi_pc_rdata = '0; rvfi_pc_wdata = '0;
    rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("init_valid", 64'(out_valid), 64'd0);
    chk("init_level", 64'(level), 64'd0);
    chk("init_rec",   64'(out_rec != '0), 64'd0);
    check_flags("init");
    rst_n = 1'b1;

    // single lane stream, always ready
    for (int i = 0; i < 5; i++) step(2'b01, 64'(i), 64'hDEAD, 2'b00, 1'b1);
    drain();
    chk("s1_flags", {61'd0, overflow, order_err, halted}, 64'd0);

    // overflow: four pairs fill 8 entries, fifth and sixth pairs dropped
    do_reset();
    for (int b = 0; b < 4; b++) step(2'b11, 64'(2*b), 64'(2*b+1), 2'b00, 1'b0);
    chk("s2_full", 64'(level), 64'd8);
    step(2'b11, 64'd8, 64'd9, 2'b00, 1'b0);
    chk("s2_ovf", 64'(overflow), 64'd1);
    chk("s2_drop", 64'(drop_cnt), 64'd2);
    step(2'b11, 64'd10, 64'd11, 2'b00, 1'b0);
    chk("s2_drop2", 64'(drop_cnt), 64'd4);
    drain();

    // order gap
    do_reset();
    step(2'b01, 64'd0, 64'd0, 2'b00, 1'b1);
    step(2'b01, 64'd1, 64'd0, 2'b00, 1'b1);
    step(2'b01, 64'd3, 64'd0, 2'b00, 1'b1);
    chk("s3_err", 64'(order_err), 64'd1);
    chk("s3_eord", err_order, 64'd3);
    step(2'b01, 64'd4, 64'd0, 2'b00, 1'b1);
    chk("s3_eord_kept", err_order, 64'd3);
    drain();

    // halt on lane 0 discards lane 1 and freezes capture
    do_reset();
    step(2'b11, 64'd0, 64'd1, 2'b01, 1'b0);
    chk("s4_halt", 64'(halted), 64'd1);
    chk("s4_level", 64'(level), 64'd1);
    step(2'b11, 64'd1, 64'd2, 2'b00, 1'b0);
    step(2'b01, 64'd3, 64'd0, 2'b00, 1'b0);
    chk("s4_frozen_level", 64'(level), 64'd1);
    chk("s4_drop", 64'(drop_cnt), 64'd0);
    drain();

    // near-full with simultaneous pop
    do_reset();
    for (int b = 0; b < 3; b++) step(2'b11, 64'(2*b), 64'(2*b+1), 2'b00, 1'b0);
    step(2'b01, 64'd6, 64'd0, 2'b00, 1'b0);
    chk("s5_lvl7", 64'(level), 64'd7);
    step(2'b01, 64'd7, 64'd0, 2'b00, 1'b1);
    chk("s5_pushpop", 64'(level), 64'd7);
    step(2'b11, 64'd8, 64'd9, 2'b00, 1'b1);
    chk("s5_drop_lvl", 64'(level), 64'd6);
    chk("s5_drop", 64'(drop_cnt), 64'd2);
    drain();

    // async reset mid-stream at level 7, then restart from order 0
    do_reset();
    for (int b = 0; b < 3; b++) step(2'b11, 64'(2*b), 64'(2*b+1), 2'b00, 1'b0);
    step(2'b01, 64'd6, 64'd0, 2'b00, 1'b0);
    chk("s6_lvl7", 64'(level), 64'd7);
    do_reset();
    step(2'b01, 64'd0, 64'd0, 2'b00, 1'b1);
    chk("s6_noerr", 64'(order_err), 64'd0);
    drain();

    do_reset();
    rand_run(400, 70);
    do_reset();
    rand_run(400, 30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
